dft_mac_engine: RTL and testbench

//  Parametrised direct-DFT engine: X[k] = sum_n x[n]*W^(k*n), W = exp(-/+j*2*pi/N), runtime N.

---
 rtl/dft_mac_engine.sv | 238 +++++++++++++++++++++++
 tb/tb_dft_mac_engine.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dft_mac_engine.sv
// Direct-form DFT engine: buffers N complex samples, then issues one complex MAC per
// cycle against an external synchronous twiddle ROM and streams each bin out.
module dft_mac_engine #(
  parameter int MAX_N  = 64,
  parameter int DATA_W = 16,
  parameter int TW_W   = 16,
  parameter int OUT_W  = 16,
  parameter int SCALE  = 0,
  parameter int AW     = $clog2(MAX_N)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [AW:0]              samp_num_i,
  input  logic                     inverse_i,
  input  logic                     s_valid_i,
  output logic                     s_ready_o,
  input  logic signed [DATA_W-1:0] s_re_i,
  input  logic signed [DATA_W-1:0] s_im_i,
  output logic [AW-1:0]            tw_addr_o,
  input  logic signed [TW_W-1:0]   tw_re_i,
  input  logic signed [TW_W-1:0]   tw_im_i,
  output logic                     m_valid_o,
  input  logic                     m_ready_i,
  output logic signed [OUT_W-1:0]  m_re_o,
  output logic signed [OUT_W-1:0]  m_im_o,
  output logic [AW-1:0]            m_index_o,
  output logic                     m_last_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     sat_o,
  output logic                     err_o
);

  localparam int PW  = DATA_W + TW_W + 1;
  localparam int ACW = DATA_W + TW_W + AW + 2;
  localparam int S   = TW_W - 1 + SCALE;

  localparam logic [AW:0] ONE   = (AW+1)'(1);
  localparam logic [AW:0] N_MIN = (AW+1)'(2);
  localparam logic [AW:0] N_MAX = (AW+1)'(MAX_N);

  localparam logic signed [ACW-1:0] HALF    = ACW'(1) <<< (S - 1);
  localparam logic signed [ACW-1:0] OUT_MAX = (ACW'(1) <<< (OUT_W - 1)) - ACW'(1);
  localparam logic signed [ACW-1:0] OUT_MIN = -(ACW'(1) <<< (OUT_W - 1));

  typedef enum logic [2:0] {IDLE, LOAD, CALC, DRAIN, OUT} state_t;

  state_t              state_q;
  logic [AW:0]         len_q, n_q, k_q, idx_q, idx_d, idxSum, lastN;
  logic                inv_q;
  logic [1:0]          drain_q;
  logic                s_ready_q, m_valid_q, m_last_q, busy_q, done_q, sat_q, err_q;
  logic [AW-1:0]       m_index_q;
  logic signed [OUT_W-1:0] m_re_q, m_im_q;

  logic signed [DATA_W-1:0] bufRe_q [MAX_N];
  logic signed [DATA_W-1:0] bufIm_q [MAX_N];
  logic signed [DATA_W-1:0] xr_q, xi_q;
  logic                     v1_q, f1_q, v2_q, f2_q;
  logic signed [PW-1:0]     xrE, xiE, wrE, wiE, pr_d, pi_d, pr_q, pi_q;
  logic signed [ACW-1:0]    accRe_q, accIm_q, rndRe, rndIm;
  logic signed [OUT_W-1:0]  resRe, resIm;
  logic                     clipRe, clipIm;

  function automatic logic [OUT_W:0] saturate(input logic signed [ACW-1:0] v);
    if (v > OUT_MAX)      return {1'b1, OUT_MAX[OUT_W-1:0]};
    else if (v < OUT_MIN) return {1'b1, OUT_MIN[OUT_W-1:0]};
    else                  return {1'b0, v[OUT_W-1:0]};
  endfunction

  assign lastN = len_q - ONE;

  // Twiddle index walks k*n mod N by repeated addition; idx,k < N so one subtract suffices.
  always_comb begin
    idxSum = idx_q + k_q;
    idx_d  = (idxSum >= len_q) ? idxSum - len_q : idxSum;
  end

  always_comb begin
    xrE  = PW'(xr_q);
    xiE  = PW'(xi_q);
    wrE  = PW'(tw_re_i);
    wiE  = inv_q ? -PW'(tw_im_i) : PW'(tw_im_i);
    pr_d = xrE * wrE - xiE * wiE;
    pi_d = xrE * wiE + xiE * wrE;
  end

  always_comb begin
    rndRe = (accRe_q + HALF) >>> S;
    rndIm = (accIm_q + HALF) >>> S;
    {clipRe, resRe} = saturate(rndRe);
    {clipIm, resIm} = saturate(rndIm);
  end

  always_ff @(posedge clk_i) begin
    if (state_q == LOAD && s_valid_i) begin
      bufRe_q[n_q[AW-1:0]] <= s_re_i;
      bufIm_q[n_q[AW-1:0]] <= s_im_i;
    end
    xr_q <= bufRe_q[n_q[AW-1:0]];
    xi_q <= bufIm_q[n_q[AW-1:0]];
  end

  // Three-stage MAC: buffer/ROM read, product register, accumulate.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v1_q    <= 1'b0;
      f1_q    <= 1'b0;
      v2_q    <= 1'b0;
      f2_q    <= 1'b0;
      pr_q    <= '0;
      pi_q    <= '0;
      accRe_q <= '0;
      accIm_q <= '0;
    end else begin
      v1_q <= (state_q == CALC);
      f1_q <= (state_q == CALC) && (n_q == '0);
      v2_q <= v1_q;
      f2_q <= f1_q;
      pr_q <= pr_d;
      pi_q <= pi_d;
      if (v2_q) begin
        accRe_q <= f2_q ? ACW'(pr_q) : accRe_q + ACW'(pr_q);
        accIm_q <= f2_q ? ACW'(pi_q) : accIm_q + ACW'(pi_q);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      len_q     <= '0;
      inv_q     <= 1'b0;
      n_q       <= '0;
      k_q       <= '0;
      idx_q     <= '0;
      drain_q   <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_index_q <= '0;
      m_re_q    <= '0;
      m_im_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sat_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            if (samp_num_i < N_MIN || samp_num_i > N_MAX) begin
              err_q <= 1'b1;
            end else begin
              len_q     <= samp_num_i;
              inv_q     <= inverse_i;
              sat_q     <= 1'b0;
              n_q       <= '0;
              s_ready_q <= 1'b1;
              busy_q    <= 1'b1;
              state_q   <= LOAD;
            end
          end
        end
        LOAD: begin
          if (s_valid_i) begin
            if (n_q == lastN) begin
              n_q       <= '0;
              k_q       <= '0;
              idx_q     <= '0;
              s_ready_q <= 1'b0;
              state_q   <= CALC;
            end else begin
              n_q <= n_q + ONE;
            end
          end
        end
        CALC: begin
          if (n_q == lastN) begin
            n_q     <= '0;
            idx_q   <= '0;
            drain_q <= '0;
            state_q <= DRAIN;
          end else begin
            n_q   <= n_q + ONE;
            idx_q <= idx_d;
          end
        end
        DRAIN: begin
          // Last drain cycle sees the final accumulator, so the bin is registered here.
          if (drain_q == 2'd2) begin
            m_valid_q <= 1'b1;
            m_re_q    <= resRe;
            m_im_q    <= resIm;
            m_index_q <= k_q[AW-1:0];
            m_last_q  <= (k_q == lastN);
            sat_q     <= sat_q | clipRe | clipIm;
            state_q   <= OUT;
          end else begin
            drain_q <= drain_q + 2'd1;
          end
        end
        OUT: begin
          if (m_ready_i) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            if (k_q == lastN) begin
              k_q     <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              k_q     <= k_q + ONE;
              state_q <= CALC;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_ready_o = s_ready_q;
  assign tw_addr_o = idx_q[AW-1:0];
  assign m_valid_o = m_valid_q;
  assign m_re_o    = m_re_q;
  assign m_im_o    = m_im_q;
  assign m_index_o = m_index_q;
  assign m_last_o  = m_last_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign sat_o     = sat_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_dft_mac_engine.sv
// Testbench for dft_mac_engine: a table of small directed transforms plus hand-written
// sequences for backpressure, bad lengths, reset abort and full-length saturation.
module tb_dft_mac_engine;

  localparam int MAX_N = 64;
  localparam int AW    = 6;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [AW:0]        sampNum;
  logic               inverse;
  logic               sValid;
  logic               sReady;
  logic signed [15:0] sRe, sIm;
  logic [AW-1:0]      twAddr;
  logic signed [15:0] twRe, twIm;
  logic               mValid;
  logic               mReady;
  logic signed [15:0] mRe, mIm;
  logic [AW-1:0]      mIndex;
  logic               mLast, busy, done, sat, err;

  int checks = 0;
  int errors = 0;

  logic signed [15:0] romRe [MAX_N];
  logic signed [15:0] romIm [MAX_N];
  int sampRe [MAX_N];
  int sampIm [MAX_N];

  typedef struct {
    int               n;
    logic             inv;
    logic [7:0][15:0] xRe;
    logic [7:0][15:0] xIm;
    logic [7:0][15:0] yRe;
    logic [7:0][15:0] yIm;
  } vec_t;

  vec_t vecs [6];

  dft_mac_engine dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .samp_num_i (sampNum),
    .inverse_i  (inverse),
    .s_valid_i  (sValid),
    .s_ready_o  (sReady),
    .s_re_i     (sRe),
    .s_im_i     (sIm),
    .tw_addr_o  (twAddr),
    .tw_re_i    (twRe),
    .tw_im_i    (twIm),
    .m_valid_o  (mValid),
    .m_ready_i  (mReady),
    .m_re_o     (mRe),
    .m_im_o     (mIm),
    .m_index_o  (mIndex),
    .m_last_o   (mLast),
    .busy_o     (busy),
    .done_o     (done),
    .sat_o      (sat),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    twRe <= romRe[twAddr];
    twIm <= romIm[twAddr];
  end

  function automatic logic signed [15:0] toQ15(input real v);
    int r;
    r = (v >= 0.0) ? $rtoi(v * 32767.0 + 0.5) : -$rtoi(-v * 32767.0 + 0.5);
    return 16'(r);
  endfunction

  task automatic loadRom(input int n);
    real ang;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < n) begin
        ang = 2.0 * 3.14159265358979 * i / n;
        romRe[i] = toQ15($cos(ang));
        romIm[i] = toQ15(-$sin(ang));
      end else begin
        romRe[i] = '0;
        romIm[i] = '0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out waiting, got no event, expected one", name);
  endtask

  task automatic applyStimulus(input int n, input logic inv);
    int  waitCnt;
    logic accepted;
    loadRom(n);
    sampNum = 7'(n);
    inverse = inv;
    start   = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("busy_after_start", busy, 1);
    checkOutput("sat_cleared_on_start", sat, 0);
    for (int i = 0; i < n; i++) begin
      sValid  = 1'b1;
      sRe     = 16'(sampRe[i]);
      sIm     = 16'(sampIm[i]);
      waitCnt = 0;
      accepted = 1'b0;
      while (!accepted && waitCnt < 50) begin
        accepted = sReady;
        tick();
        waitCnt++;
      end
      if (!accepted) begin
        reportTimeout($sformatf("s_ready_sample%0d", i));
        break;
      end
    end
    sValid = 1'b0;
  endtask

  task automatic recvBin(input string tag, input int expRe, input int expIm, input int expIdx,
                         input int expLast, input int expLat, input bit chkVal);
    int cnt;
    cnt = 0;
    while (!mValid && cnt < 200) begin
      tick();
      cnt++;
    end
    if (!mValid) begin
      reportTimeout({tag, "_m_valid"});
      return;
    end
    checkOutput({tag, "_latency"}, cnt, expLat);
    checkOutput({tag, "_index"}, mIndex, expIdx);
    checkOutput({tag, "_last"}, mLast, expLast);
    if (chkVal) begin
      checkOutput({tag, "_re"}, mRe, expRe);
      checkOutput({tag, "_im"}, mIm, expIm);
    end
  endtask

  task automatic ackBin(input bit isLast);
    mReady = 1'b1;
    tick();
    mReady = 1'b0;
    checkOutput("m_valid_drop", mValid, 0);
    checkOutput("done_pulse", done, isLast);
    checkOutput("busy_after_bin", busy, !isLast);
    if (isLast) begin
      tick();
      checkOutput("done_one_cycle", done, 0);
    end
  endtask

  task automatic setCase(input int c, input int n, input logic inv);
    vecs[c].n   = n;
    vecs[c].inv = inv;
    vecs[c].xRe = '0;
    vecs[c].xIm = '0;
    vecs[c].yRe = '0;
    vecs[c].yIm = '0;
  endtask

  task automatic setX(input int c, input int i, input int re, input int im);
    vecs[c].xRe[i] = 16'(re);
    vecs[c].xIm[i] = 16'(im);
  endtask

  task automatic setY(input int c, input int k, input int re, input int im);
    vecs[c].yRe[k] = 16'(re);
    vecs[c].yIm[k] = 16'(im);
  endtask

  task automatic loadSamples(input int c);
    for (int i = 0; i < MAX_N; i++) begin
      sampRe[i] = 0;
      sampIm[i] = 0;
    end
    for (int i = 0; i < vecs[c].n; i++) begin
      sampRe[i] = int'($signed(vecs[c].xRe[i]));
      sampIm[i] = int'($signed(vecs[c].xIm[i]));
    end
  endtask

  task automatic runCase(input int c);
    int n;
    n = vecs[c].n;
    loadSamples(c);
    applyStimulus(n, vecs[c].inv);
    for (int k = 0; k < n; k++) begin
      recvBin($sformatf("case%0d_bin%0d", c, k), int'($signed(vecs[c].yRe[k])),
              int'($signed(vecs[c].yIm[k])), k, (k == n - 1), n + 3, 1'b1);
      ackBin(k == n - 1);
    end
    checkOutput($sformatf("case%0d_sat", c), sat, 0);
  endtask

  initial begin
    int badN [3];
    rst     = 1'b1;
    start   = 1'b0;
    sampNum = '0;
    inverse = 1'b0;
    sValid  = 1'b0;
    sRe     = '0;
    sIm     = '0;
    mReady  = 1'b0;
    loadRom(4);
    tick();
    tick();
    checkOutput("reset_m_valid", mValid, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_s_ready", sReady, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_err", err, 0);
    checkOutput("reset_sat", sat, 0);
    checkOutput("reset_tw_addr", twAddr, 0);
    rst = 1'b0;
    tick();

    setCase(0, 4, 1'b0);
    for (int i = 0; i < 4; i++) setX(0, i, 100, 0);
    setY(0, 0, 400, 0);

    setCase(1, 8, 1'b0);
    setX(1, 0, 1000, -500);
    for (int k = 0; k < 8; k++) setY(1, k, 1000, -500);

    setCase(2, 8, 1'b1);
    setX(2, 0, 1000, -500);
    for (int k = 0; k < 8; k++) setY(2, k, 1000, -500);

    setCase(3, 4, 1'b0);
    setX(3, 1, 1000, 0);
    setY(3, 0, 1000, 0);
    setY(3, 1, 0, -1000);
    setY(3, 2, -1000, 0);
    setY(3, 3, 0, 1000);

    setCase(4, 4, 1'b1);
    setX(4, 1, 1000, 0);
    setY(4, 0, 1000, 0);
    setY(4, 1, 0, 1000);
    setY(4, 2, -1000, 0);
    setY(4, 3, 0, -1000);

    setCase(5, 2, 1'b0);
    setX(5, 0, 300, 0);
    setX(5, 1, 100, 50);
    setY(5, 0, 400, 50);
    setY(5, 1, 200, -50);

    for (int c = 0; c < 6; c++) runCase(c);

    // Backpressure at k=2 with a stray start pulse that must be ignored.
    loadSamples(4);
    applyStimulus(4, 1'b1);
    for (int k = 0; k < 2; k++) begin
      recvBin($sformatf("hold_bin%0d", k), int'($signed(vecs[4].yRe[k])),
              int'($signed(vecs[4].yIm[k])), k, 0, 7, 1'b1);
      ackBin(1'b0);
    end
    recvBin("hold_bin2", -1000, 0, 2, 0, 7, 1'b1);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        sampNum = 7'(2);
        start   = 1'b1;
      end
      tick();
      start = 1'b0;
      checkOutput("hold_valid", mValid, 1);
      checkOutput("hold_re", mRe, -1000);
      checkOutput("hold_im", mIm, 0);
      checkOutput("hold_index", mIndex, 2);
    end
    ackBin(1'b0);
    recvBin("hold_bin3", 0, -1000, 3, 1, 7, 1'b1);
    ackBin(1'b1);

    badN = '{1, 65, 0};
    for (int i = 0; i < 3; i++) begin
      sampNum = 7'(badN[i]);
      start   = 1'b1;
      tick();
      start = 1'b0;
      checkOutput($sformatf("err_pulse_n%0d", badN[i]), err, 1);
      checkOutput($sformatf("err_busy_n%0d", badN[i]), busy, 0);
      tick();
      checkOutput($sformatf("err_clear_n%0d", badN[i]), err, 0);
      checkOutput($sformatf("err_s_ready_n%0d", badN[i]), sReady, 0);
    end

    loadSamples(1);
    applyStimulus(8, 1'b0);
    tick();
    tick();
    tick();
    checkOutput("abort_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    checkOutput("abort_m_valid", mValid, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_s_ready", sReady, 0);
    checkOutput("abort_tw_addr", twAddr, 0);
    tick();
    rst = 1'b0;
    tick();
    checkOutput("abort_busy_after", busy, 0);
    runCase(5);

    for (int i = 0; i < MAX_N; i++) begin
      sampRe[i] = 32767;
      sampIm[i] = 0;
    end
    applyStimulus(MAX_N, 1'b0);
    recvBin("full_bin0", 32767, 0, 0, 0, MAX_N + 3, 1'b1);
    checkOutput("full_sat_set", sat, 1);
    ackBin(1'b0);
    for (int k = 1; k < MAX_N; k++) begin
      recvBin($sformatf("full_bin%0d", k), 0, 0, k, (k == MAX_N - 1), MAX_N + 3, 1'b0);
      ackBin(k == MAX_N - 1);
    end
    checkOutput("full_sat_sticky", sat, 1);
    runCase(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
